// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and default sizes for the systolic preload controller
package systolic_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int BITS_AB_DEF = 8;
    localparam int DIM_DEF     = 8;

endpackage

// File: rtl/systolic_load_ctrl.sv
// rtl/systolic_load_ctrl.sv - row loader and drain sequencer for the preload FIFOs
// Optional abort input enabled by SYSTOLIC_LOAD_ABORT_EN.
module systolic_load_ctrl
    import systolic_pkg::*;
#(
    parameter int  BITS_AB = BITS_AB_DEF,
    parameter int  DIM     = DIM_DEF,
    localparam int RW      = $clog2(DIM),
    localparam int DRAIN   = 2 * DIM - 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [RW-1:0]                    ld_row,
    input  logic signed [DIM-1:0][BITS_AB-1:0] ld_data,
    input  logic                             start,
`ifdef SYSTOLIC_LOAD_ABORT_EN
    input  logic                             abort,
`endif
    output logic                             mem_en,
    output logic                             mem_wr,
    output logic [RW-1:0]                    mem_row,
    output logic signed [DIM-1:0][BITS_AB-1:0] mem_data,
    output logic [DIM-1:0]                   loaded,
    output logic                             busy,
    output logic                             done
);

    localparam int            CW       = $clog2(DRAIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          abort_hit;

`ifdef SYSTOLIC_LOAD_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_row  = '0;
        mem_data = '0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_wr   = 1'b1;
                    mem_row  = ld_row;
                    mem_data = ld_data;
                end
                // Uses the registered mask, so a start alongside the last write is ignored.
                if (start && (&loaded)) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                mem_en = 1'b1;
                if (abort_hit) begin
                    state_nx = LOAD;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = LOAD;
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            cnt    <= '0;
            loaded <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == STREAM);
            done  <= (state_nx == DONE);
            if (state == STREAM && state_nx == STREAM) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state == DONE || (state == STREAM && abort_hit)) begin
                loaded <= '0;
            end else if (mem_wr) begin
                loaded[mem_row] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_load_ctrl.sv
// tb/tb_systolic_load_ctrl.sv - scoreboard bench for systolic_load_ctrl
module tb_systolic_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_row = '0;
    logic [63:0] ld_data = '0;
    logic        start = 1'b0;
`ifdef SYSTOLIC_LOAD_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  mem_row;
    logic [63:0] mem_data;
    logic [7:0]  loaded;
    logic        busy;
    logic        done;

    int n_total = 0;
    int n_pass  = 0;
    int en_run  = 0;

    typedef struct {
        bit          is_done;
        logic [2:0]  row;
        logic [63:0] data;
        int          len;
    } exp_t;

    exp_t sb[$];

    systolic_load_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_row   (ld_row),
        .ld_data  (ld_data),
        .start    (start),
`ifdef SYSTOLIC_LOAD_ABORT_EN
        .abort    (abort),
`endif
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_row  (mem_row),
        .mem_data (mem_data),
        .loaded   (loaded),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a row write or a done pulse.
    always @(negedge clk) begin
        exp_t e;
        logic abort_seen;
        abort_seen = rst;
`ifdef SYSTOLIC_LOAD_ABORT_EN
        abort_seen = abort_seen | abort;
`endif
        if (abort_seen) en_run = 0;
        else if (mem_en) en_run++;
        if (mem_wr) begin
            chk("wr_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_kind", e.is_done, 0);
                chk("wr_row", mem_row, e.row);
                chk("wr_data", mem_data, e.data);
            end
        end
        if (done) begin
            chk("done_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_kind", e.is_done, 1);
                chk("drain_len", en_run, e.len);
            end
            en_run = 0;
        end
    end

    task automatic push_wr(input logic [2:0] r, input logic [63:0] d);
        exp_t e;
        e.is_done = 1'b0; e.row = r; e.data = d; e.len = 0;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.row = '0; e.data = '0; e.len = 15;
        sb.push_back(e);
    endtask

    task automatic write_row(input int r, input logic [63:0] d);
        ld_valid = 1'b1;
        ld_row   = 3'(r);
        ld_data  = d;
        push_wr(3'(r), d);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < 8; r++) write_row(r, {8{8'(r)}});
    endtask

    // Called at a negedge inside STREAM; returns at the negedge showing done.
    task automatic wait_done(input bit stall_chk, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (busy) ncyc++;
            if (stall_chk) begin
                chk("stall_ready", ld_ready, 0);
                chk("stall_wr", mem_wr, 0);
            end
            @(negedge clk);
        end
        chk("done_seen", done, 1);
    endtask

    task automatic rst_or_abort_midstream(input bit use_abort);
        int ndone;
        load_all();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        if (use_abort) begin
`ifdef SYSTOLIC_LOAD_ABORT_EN
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
`endif
        end else begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        @(negedge clk);
        chk("cut_mem_en", mem_en, 0);
        chk("cut_busy", busy, 0);
        chk("cut_loaded", loaded, 8'h00);
        chk("cut_ready", ld_ready, 1);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("cut_no_done", ndone, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int ncyc;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_loaded", loaded, 8'h00);
        chk("rst_ready", ld_ready, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        @(posedge clk); #1;

        // Rows 0..6, duplicate write to row 3, then a start that must be ignored.
        for (int r = 0; r < 7; r++) write_row(r, {8{8'(r)}});
        write_row(3, 64'h0102030405060708);
        @(negedge clk);
        chk("dup_loaded", loaded, 8'h7F);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("early_busy", busy, 0);
        chk("early_mem_en", mem_en, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("early_busy2", busy, 0);
        chk("early_mem_en2", mem_en, 0);
        @(posedge clk); #1;

        // Start together with the row-7 write is ignored; held one more cycle it streams.
        start = 1'b1;
        write_row(7, {8{8'd7}});
        @(negedge clk);
        chk("race_busy", busy, 0);
        chk("full_loaded", loaded, 8'hFF);
        push_done();
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("stream_busy", busy, 1);
        chk("stream_mem_en", mem_en, 1);
        wait_done(1'b0, ncyc);
        chk("stream_cycles", ncyc, 15);
        chk("done_mem_en", mem_en, 0);
        @(negedge clk);
        chk("post_loaded", loaded, 8'h00);
        chk("post_ready", ld_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        @(posedge clk); #1;

        // ld_valid held through STREAM stalls until the first LOAD cycle.
        load_all();
        start = 1'b1;
        push_done();
        @(posedge clk); #1;
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_row   = 3'd2;
        ld_data  = {8{8'hA5}};
        push_wr(3'd2, {8{8'hA5}});
        @(negedge clk);
        wait_done(1'b1, ncyc);
        chk("stall_cycles", ncyc, 15);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("stall_loaded", loaded, 8'h04);
        @(posedge clk); #1;

        rst_or_abort_midstream(1'b0);
`ifdef SYSTOLIC_LOAD_ABORT_EN
        rst_or_abort_midstream(1'b1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/systolic_load_ctrl.md
SYSTOLIC_LOAD_CTRL -- requirements
Module: systolic_load_ctrl

Interface
REQ-001 Parameter BITS_AB, default 8: signed element width of one matrix-A entry.
REQ-002 Parameter DIM, default 8: array dimension; number of rows and lanes; power of two, at least 2.
REQ-003 Localparam RW = $clog2(DIM): row-index width. Localparam DRAIN = 2*DIM-1: stream length in cycles.
REQ-004 clk  in  1  sole clock; all state on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ld_valid  in  1  host offers one row write.
REQ-007 ld_ready  out  1  controller accepts the row write this cycle.
REQ-008 ld_row  in  RW  row index of the offered write.
REQ-009 ld_data  in  DIM x BITS_AB signed  row contents of the offered write.
REQ-010 start  in  1  request to stream the loaded matrix.
REQ-011 mem_en  out  1  shift enable to the preload FIFOs.
REQ-012 mem_wr  out  1  row write enable to the preload FIFOs.
REQ-013 mem_row  out  RW  row select to the preload FIFOs.
REQ-014 mem_data  out  DIM x BITS_AB signed  row data to the preload FIFOs.
REQ-015 loaded  out  DIM  bitmask of rows written since the last clear.
REQ-016 busy  out  1  high in STREAM.
REQ-017 done  out  1  one-cycle pulse when a stream completes.

Function
REQ-018 FSM states: LOAD, STREAM, DONE.
REQ-019 LOAD: ld_ready=1. A write is accepted on ld_valid && ld_ready.
REQ-020 On acceptance, mem_wr=1, mem_row=ld_row and mem_data=ld_data in the same cycle (combinational pass-through); loaded[ld_row] sets on the next edge.
REQ-021 A duplicate row write is accepted and overwrites that row; loaded is unchanged.
REQ-022 LOAD->STREAM when start=1 and the registered loaded is all-ones. Otherwise start is ignored, with no error and no state change.
REQ-023 Start arriving in the same cycle as the final row write is ignored, because loaded is not yet full.
REQ-024 STREAM: ld_ready=0 and mem_wr=0. mem_en=1 for exactly DRAIN consecutive cycles, counted by cnt from 0 to DRAIN-1.
REQ-025 The counter is wide enough to hold DRAIN-1 without wrap. On cnt==DRAIN-1, STREAM->DONE.
REQ-026 DONE lasts one cycle: done=1, mem_en=0, loaded clears to 0; then DONE->LOAD.
REQ-027 Outside the cycles named above, mem_en=0 and mem_wr=0. When mem_wr=0, mem_row and mem_data are don't-care but driven deterministically.
REQ-028 ld_valid during STREAM or DONE stalls; no write reaches the FIFOs.

Reset
REQ-029 rst=1 forces, on the next edge: state=LOAD, cnt=0, loaded=0.
REQ-030 The registered outputs reset as busy=0 and done=0. While in LOAD, mem_en=0 and mem_wr=0 unless a write is accepted.
REQ-031 rst asserted mid-STREAM aborts the stream with no done pulse; the loaded matrix is discarded.

Configuration
REQ-032 Macro SYSTOLIC_LOAD_ABORT_EN.
REQ-033 When SYSTOLIC_LOAD_ABORT_EN is defined, input port abort (1 bit) exists. abort=1 in STREAM goes to LOAD on the next edge, with loaded cleared, cnt=0 and no done pulse. abort is ignored in LOAD and DONE.
REQ-034 When SYSTOLIC_LOAD_ABORT_EN is undefined, the abort port is absent and STREAM always runs the full DRAIN cycles.

Structure
REQ-035 The shared package systolic_pkg holds the state enum type (LOAD, STREAM, DONE) and the default BITS_AB and DIM constants.
REQ-036 No sub-module: the controller is a single module and instantiates the preload-FIFO memory only at the parent level.

Verification
REQ-037 Reset, then write rows 0..7 with ld_data row r = {r,r,...}. Required: mem_wr pulses 8 times with mem_row=r; loaded=8'hFF after the last write.
REQ-038 Start with loaded=8'h7F. Required: ignored; busy stays 0 and mem_en stays 0.
REQ-039 Full load, then start. Required: busy=1 and mem_en=1 for exactly 15 cycles; then done=1 for 1 cycle, loaded=0 and ld_ready=1 in the following cycle.
REQ-040 Start asserted in the same cycle as the row-7 write. Required: no stream. Start held one more cycle. Required: stream begins.
REQ-041 ld_valid held high throughout STREAM. Required: ld_ready=0 and mem_wr=0 for all 15 cycles; the write is accepted in the first LOAD cycle after DONE.
REQ-042 rst pulsed at STREAM cycle 5, and with SYSTOLIC_LOAD_ABORT_EN defined, abort pulsed at cycle 5. Required in both cases: mem_en=0 from the next cycle, no done pulse, loaded=0.
